// File: rtl/trig_frame_reader_pkg.sv
// Shared types and constants for the triggered frame reader.
package trig_frame_reader_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

endpackage

// File: rtl/frame_buffer_ram.sv
// Display buffer: one write port, one synchronous read port.
// Reads return the old contents when the same address is written in that cycle.
module frame_buffer_ram
  import trig_frame_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read, output register cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trig_frame_reader.sv
// Strobes the sample cache, hunts for a level/edge trigger and stores
// one DEPTH-sample frame into the display buffer.
module trig_frame_reader
  import trig_frame_reader_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter int CS_LOW_CYC   = 4,
  parameter int CS_HIGH_CYC  = 4,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              auto_mode,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] AD_digits_in,
  output logic              CS_N,
  output logic              busy,
  output logic              frame_valid,
  output logic              frame_done,
  output logic              timed_out,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PERIOD = CS_LOW_CYC + CS_HIGH_CYC;
  localparam int TMR_W  = $clog2(PERIOD);
  localparam int CNT_W  = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [TMR_W-1:0]  LAST_LOW   = TMR_W'(CS_LOW_CYC - 1);
  localparam logic [TMR_W-1:0]  FIRST_HIGH = TMR_W'(CS_LOW_CYC);
  localparam logic [TMR_W-1:0]  LAST_TMR   = TMR_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  AUTO_LAST  = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  AUTO_SAT   = CNT_W'(AUTO_TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                timed_out_q, timed_out_d;
  logic                have_prev_q, have_prev_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]    seek_cnt_q, seek_cnt_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

  logic                act, cap, start;
  logic                hit_rise, hit_fall, hit_trig, hit_auto;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_ptr;

  // Next-state, strobe timer and trigger evaluation.
  always_comb begin
    act      = (state_q == ST_SEEK) || (state_q == ST_CAPTURE);
    cap      = act && (tmr_q == LAST_LOW);
    hit_rise = (prev_q < trig_level) && (AD_digits_in >= trig_level);
    hit_fall = (prev_q > trig_level) && (AD_digits_in <= trig_level);
    hit_trig = have_prev_q && ((trig_edge == TRIG_FALLING) ? hit_fall : hit_rise);
    // seek_cnt counts samples already seen, so this fires on the AUTO_TIMEOUT-th one
    hit_auto = auto_mode && (seek_cnt_q >= AUTO_LAST);

    state_d      = state_q;
    frame_done_d = 1'b0;
    timed_out_d  = timed_out_q;
    have_prev_d  = have_prev_q;
    prev_d       = prev_q;
    seek_cnt_d   = seek_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_en        = 1'b0;
    wr_ptr       = wr_addr_q;
    start        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) start = 1'b1;
      end
      ST_SEEK: begin
        if (cap) begin
          prev_d      = AD_digits_in;
          have_prev_d = 1'b1;
          if (seek_cnt_q != AUTO_SAT) seek_cnt_d = seek_cnt_q + 1'b1;
          if (hit_trig || hit_auto) begin
            // trigger sample is the first frame entry
            state_d     = ST_CAPTURE;
            wr_en       = 1'b1;
            wr_ptr      = '0;
            wr_addr_d   = ADDR_W'(1);
            timed_out_d = !hit_trig;
          end
        end
      end
      ST_CAPTURE: begin
        if (cap) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == ADDR_LAST) begin
            frame_done_d = 1'b1;
            // arm on the finishing capture re-arms straight into SEEK
            if (arm) start = 1'b1;
            else     state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (arm) start = 1'b1;
      end
    endcase

    if (start) begin
      state_d     = ST_SEEK;
      timed_out_d = 1'b0;
      have_prev_d = 1'b0;
      seek_cnt_d  = '0;
      wr_addr_d   = '0;
    end

    busy_d        = (state_d == ST_SEEK) || (state_d == ST_CAPTURE);
    frame_valid_d = (state_d == ST_DONE);

    // timer free-runs while busy; it restarts at the low phase only from idle/done
    if (!busy_d || !act)      tmr_d = '0;
    else if (tmr_q == LAST_TMR) tmr_d = '0;
    else                      tmr_d = tmr_q + 1'b1;

    cs_n_d = !busy_d || (tmr_d >= FIRST_HIGH);
  end

  // Single state/output register bank.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      cs_n_q        <= 1'b1;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      timed_out_q   <= 1'b0;
      have_prev_q   <= 1'b0;
      prev_q        <= '0;
      seek_cnt_q    <= '0;
      wr_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      cs_n_q        <= cs_n_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      timed_out_q   <= timed_out_d;
      have_prev_q   <= have_prev_d;
      prev_q        <= prev_d;
      seek_cnt_q    <= seek_cnt_d;
      wr_addr_q     <= wr_addr_d;
    end
  end

  assign CS_N        = cs_n_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign timed_out   = timed_out_q;

  frame_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (sys_clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (AD_digits_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_trig_frame_reader.sv
// Scoreboarded bench: a cache model feeds sample sequences, a reference
// model predicts the frame, monitors compare frame_done and readback data.
module tb_trig_frame_reader;

  localparam int DEPTH   = 256;
  localparam int AUTO_TO = 1024;
  localparam int CS_LOW  = 4;
  localparam int CS_HIGH = 4;
  localparam int SEQ_N   = 2048;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm_s = 1'b0;
  logic       arm_c = 1'b0;
  logic       arm;
  logic       auto_mode = 1'b0;
  logic       trig_edge = 1'b0;
  logic [7:0] trig_level = 8'h00;
  logic [7:0] AD_digits_in = 8'h00;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       CS_N, busy, frame_valid, frame_done, timed_out;

  assign arm = arm_s | arm_c;

  always #5 sys_clk = ~sys_clk;

  trig_frame_reader dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .arm          (arm),
    .auto_mode    (auto_mode),
    .trig_edge    (trig_edge),
    .trig_level   (trig_level),
    .AD_digits_in (AD_digits_in),
    .CS_N         (CS_N),
    .busy         (busy),
    .frame_valid  (frame_valid),
    .frame_done   (frame_done),
    .timed_out    (timed_out),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] seq  [SEQ_N];
  logic [7:0] expf [DEPTH];

  typedef struct { bit to; bit fv; bit bz; } done_t;
  done_t      done_q[$];
  logic [7:0] rd_q[$];
  done_t      exp_d;
  logic [7:0] exp_b;
  bit         rd_chk = 1'b0;
  bit         rd_fire = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: first index whose sample meets the trigger rule, else the forced one.
  function automatic int find_trig(input logic [7:0] lvl, input bit edg, input bit am, output bit to);
    to = 1'b0;
    for (int i = 0; i < SEQ_N; i++) begin
      if (i > 0) begin
        if (!edg && seq[i-1] < lvl && seq[i] >= lvl) return i;
        if (edg && seq[i-1] > lvl && seq[i] <= lvl) return i;
      end
      if (am && i == AUTO_TO - 1) begin
        to = 1'b1;
        return i;
      end
    end
    return -1;
  endfunction

  // Cache model: each CS_N fall presents the next sample, valid only from
  // the 4th low cycle; earlier cycles carry junk.
  int fall_cnt = 0, base = 0, cur_idx = 0, low_cyc = 0;
  bit cs_prev = 1'b1;
  int rebase_req = 0, rebase_ack = 0;
  int xreq = 0, xack = 0, xarm_idx = -1;

  always @(negedge sys_clk) begin
    arm_c = 1'b0;
    if (rebase_req != rebase_ack) begin
      base = fall_cnt;
      rebase_ack = rebase_req;
    end
    if (CS_N) begin
      low_cyc = 0;
      AD_digits_in = 8'($urandom);
    end else begin
      if (cs_prev) begin
        low_cyc = 0;
        cur_idx = fall_cnt - base;
        fall_cnt++;
      end else begin
        low_cyc++;
      end
      if (low_cyc >= 3 && cur_idx >= 0 && cur_idx < SEQ_N) AD_digits_in = seq[cur_idx];
      else AD_digits_in = 8'($urandom);
      if (xreq != xack && low_cyc == 3 && cur_idx == xarm_idx) begin
        arm_c = 1'b1;
        xack = xreq;
        base = fall_cnt;
      end
    end
    cs_prev = CS_N;
  end

  // Output monitor: frame_done pulses and 1-cycle-latency readback.
  always @(posedge sys_clk) rd_fire <= rd_chk;

  always @(negedge sys_clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got data %0h with no expectation", rd_data);
      end else begin
        exp_b = rd_q.pop_front();
        chk("rd_data", rd_data, exp_b);
      end
    end
    if (frame_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_done_unexpected: got pulse, expected none");
      end else begin
        exp_d = done_q.pop_front();
        chk("timed_out_at_done", timed_out, exp_d.to);
        chk("frame_valid_at_done", frame_valid, exp_d.fv);
        chk("busy_at_done", busy, exp_d.bz);
      end
    end
  end

  // Strobe width monitor for runs that start and end while busy.
  int run_len = 0;
  bit run_busy = 1'b0;
  bit cs_last = 1'b1;
  always @(negedge sys_clk) begin
    if (CS_N !== cs_last) begin
      if (run_busy && busy)
        chk(cs_last ? "cs_high_width" : "cs_low_width", run_len, cs_last ? CS_HIGH : CS_LOW);
      run_len = 1;
      run_busy = busy;
    end else begin
      run_len++;
    end
    cs_last = CS_N;
  end

  task automatic run_frame(input logic [7:0] lvl, input bit edg, input bit am,
                           input bit xition, input bit busy_arm);
    int t;
    bit to;
    int n;
    t = find_trig(lvl, edg, am, to);
    if (t < 0 || t + DEPTH > SEQ_N) begin
      checks++; errors++;
      $display("FAIL model_trigger: got index %0d expected a usable trigger", t);
      return;
    end
    for (int i = 0; i < DEPTH; i++) expf[i] = seq[t + i];
    trig_level = lvl; trig_edge = edg; auto_mode = am;
    if (xition) begin
      xarm_idx = t + DEPTH - 1;
      xreq++;
      done_q.push_back('{1'b0, 1'b0, 1'b1});
    end
    done_q.push_back('{to, 1'b1, 1'b0});
    @(negedge sys_clk);
    arm_s = 1'b1;
    rebase_req++;
    @(negedge sys_clk);
    arm_s = 1'b0;
    chk("busy_after_arm", busy, 1);
    chk("frame_valid_after_arm", frame_valid, 0);
    chk("timed_out_after_arm", timed_out, 0);
    if (busy_arm) begin
      n = 0;
      while (n < 20000 && (fall_cnt - base) < t + 50) begin
        @(negedge sys_clk);
        n++;
      end
      arm_s = 1'b1;
      @(negedge sys_clk);
      arm_s = 1'b0;
    end
    n = 0;
    while (n < 40000 && done_q.size() != 0) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout: got %0d pending expected 0", done_q.size());
      done_q.delete();
      return;
    end
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge sys_clk);
      rd_addr = 8'(a);
      rd_chk = 1'b1;
      rd_q.push_back(expf[a]);
    end
    @(negedge sys_clk);
    rd_chk = 1'b0;
    repeat (2) @(negedge sys_clk);
    if (rd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rd_missing: got %0d unread expected 0", rd_q.size());
      rd_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_cs_n", CS_N, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // rising edge on an ascending ramp
    for (int i = 0; i < SEQ_N; i++) seq[i] = 8'((i % 16) * 16);
    run_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);

    // falling edge on a descending ramp
    for (int i = 0; i < SEQ_N; i++) seq[i] = 8'(8'hF0 - (i % 16) * 16);
    run_frame(8'h40, 1'b1, 1'b0, 1'b0, 1'b0);

    // forced trigger on a flat input
    for (int i = 0; i < SEQ_N; i++) seq[i] = 8'h20;
    run_frame(8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

    // random data, random level and edge
    repeat (2) begin
      for (int i = 0; i < SEQ_N; i++) seq[i] = 8'($urandom);
      run_frame(8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    end

    // arm pulse during capture must not restart the frame
    for (int i = 0; i < SEQ_N; i++) seq[i] = 8'($urandom);
    run_frame(8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

    // arm on the very capture that completes the frame
    for (int i = 0; i < SEQ_N; i++) seq[i] = 8'($urandom);
    run_frame(8'h80, 1'b0, 1'b1, 1'b1, 1'b0);

    // reset while CS_N is low in SEEK
    auto_mode = 1'b0;
    trig_level = 8'hFF;
    @(negedge sys_clk);
    arm_s = 1'b1;
    rebase_req++;
    @(negedge sys_clk);
    arm_s = 1'b0;
    @(negedge sys_clk);
    chk("cs_low_in_seek", CS_N, 0);
    rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_cs_n", CS_N, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_valid", frame_valid, 0);
    rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
